button_event: RTL and testbench

//  Consumes the clean level from debouncer (o_sync) and classifies user gestures.

---
 rtl/button_event.sv | 189 ++++++++++++++++++
 tb/tb_button_event.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/button_event.sv
// -----------------------------------------------------------------------------
// button_event
//
// Classifies gestures on a clean, clk-synchronous button level (typically the
// debouncer's o_sync output) and emits single-cycle event pulses for press,
// release, click, double-click and long-press. An optional auto-repeat pulse
// train is produced while the button stays held after a long-press.
//
// Optional feature macro: BUTTON_REPEAT_EN
//   defined   : o_repeat pulses every REPEAT_CYCLES while held in LONG
//   undefined : no repeat logic, o_repeat tied to 0
//
// Parameters
//   LONG_CYCLES    cycles held (from press) before o_long fires        (>=2)
//   DCLICK_CYCLES  max cycles from release to 2nd press for dclick     (>=2)
//   REPEAT_CYCLES  auto-repeat period after o_long                     (>=2)
//   ACTIVE_LOW     1: i_sync==0 means pressed
//   CNT_BITS       shared timer width
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   i_sync     debounced button level
//   o_held     registered pressed level (after polarity)
//   o_press    1-cycle pulse on every press
//   o_release  1-cycle pulse on every release
//   o_click    1-cycle pulse: short press not followed by a second press
//   o_dclick   1-cycle pulse: two short presses within DCLICK_CYCLES
//   o_long     1-cycle pulse when the hold reaches LONG_CYCLES
//   o_repeat   1-cycle auto-repeat pulse (0 without BUTTON_REPEAT_EN)
// -----------------------------------------------------------------------------
module button_event #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int DCLICK_CYCLES = 12_500_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter bit ACTIVE_LOW    = 1'b0,
  parameter int CNT_BITS      = $clog2(
      (LONG_CYCLES > DCLICK_CYCLES)
        ? ((LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES)
        : ((DCLICK_CYCLES > REPEAT_CYCLES) ? DCLICK_CYCLES : REPEAT_CYCLES)) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sync,
  output logic o_held,
  output logic o_press,
  output logic o_release,
  output logic o_click,
  output logic o_dclick,
  output logic o_long,
  output logic o_repeat
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DOWN  = 3'd1,
    GAP   = 3'd2,
    DOWN2 = 3'd3,
    LONG  = 3'd4
  } state_t;

  localparam logic [CNT_BITS-1:0] LONG_LAST   = CNT_BITS'(LONG_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] DCLICK_LAST = CNT_BITS'(DCLICK_CYCLES - 1);

  state_t              state_reg;
  logic [CNT_BITS-1:0] timer_reg;
  logic                lvl_reg;
  logic                prev_reg;
  logic                rise;
  logic                fall;

  // Edge detect on the polarity-corrected two-stage level pipeline.
  assign rise   = lvl_reg & ~prev_reg;
  assign fall   = ~lvl_reg & prev_reg;

  // prev_reg already carries the pressed level with the same latency as the
  // press/release pulses, so it is exported directly.
  assign o_held = prev_reg;

`ifdef BUTTON_REPEAT_EN
  localparam logic [CNT_BITS-1:0] REPEAT_LAST = CNT_BITS'(REPEAT_CYCLES - 1);
  logic repeat_reg;
  assign o_repeat = repeat_reg;
`else
  assign o_repeat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      lvl_reg   <= 1'b0;
      prev_reg  <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_click   <= 1'b0;
      o_dclick  <= 1'b0;
      o_long    <= 1'b0;
`ifdef BUTTON_REPEAT_EN
      repeat_reg <= 1'b0;
`endif
    end else begin
      lvl_reg   <= i_sync ^ ACTIVE_LOW;
      prev_reg  <= lvl_reg;

      // Press/release follow the level edges regardless of gesture state.
      o_press   <= rise;
      o_release <= fall;
      o_click   <= 1'b0;
      o_dclick  <= 1'b0;
      o_long    <= 1'b0;
`ifdef BUTTON_REPEAT_EN
      repeat_reg <= 1'b0;
`endif

      // Free-running saturating timer; every state change below overrides
      // this with a clear.
      if (timer_reg != '1) begin
        timer_reg <= timer_reg + 1'b1;
      end

      // Edges are tested before timer thresholds so that a coincident edge
      // wins over a timeout.
      case (state_reg)
        IDLE: begin
          if (rise) begin
            state_reg <= DOWN;
            timer_reg <= '0;
          end
        end

        DOWN: begin
          if (fall) begin
            state_reg <= GAP;
            timer_reg <= '0;
          end else if (timer_reg == LONG_LAST) begin
            state_reg <= LONG;
            timer_reg <= '0;
            o_long    <= 1'b1;
          end
        end

        GAP: begin
          if (rise) begin
            state_reg <= DOWN2;
            timer_reg <= '0;
          end else if (timer_reg == DCLICK_LAST) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            o_click   <= 1'b1;
          end
        end

        DOWN2: begin
          if (fall) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            o_dclick  <= 1'b1;
          end else if (timer_reg == LONG_LAST) begin
            // A second press that turns into a hold reports only the long.
            state_reg <= LONG;
            timer_reg <= '0;
            o_long    <= 1'b1;
          end
        end

        LONG: begin
          if (fall) begin
            state_reg <= IDLE;
            timer_reg <= '0;
          end
`ifdef BUTTON_REPEAT_EN
          else if (timer_reg == REPEAT_LAST) begin
            // Same state, so restart the period by hand.
            timer_reg  <= '0;
            repeat_reg <= 1'b1;
          end
`endif
        end

        default: begin
          state_reg <= IDLE;
          timer_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event.sv
module tb_button_event;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_sync = 1'b0;
  logic i_sync_al = 1'b1;

  logic o_held, o_press, o_release, o_click, o_dclick, o_long, o_repeat;
  logic al_held, al_press, al_release, al_click, al_dclick, al_long, al_repeat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_event #(
    .LONG_CYCLES(8), .DCLICK_CYCLES(6), .REPEAT_CYCLES(4), .ACTIVE_LOW(1'b0)
  ) u_dut (
    .clk(clk), .rst(rst), .i_sync(i_sync),
    .o_held(o_held), .o_press(o_press), .o_release(o_release),
    .o_click(o_click), .o_dclick(o_dclick), .o_long(o_long), .o_repeat(o_repeat)
  );

  button_event #(
    .LONG_CYCLES(8), .DCLICK_CYCLES(6), .REPEAT_CYCLES(4), .ACTIVE_LOW(1'b1)
  ) u_dut_al (
    .clk(clk), .rst(rst), .i_sync(i_sync_al),
    .o_held(al_held), .o_press(al_press), .o_release(al_release),
    .o_click(al_click), .o_dclick(al_dclick), .o_long(al_long), .o_repeat(al_repeat)
  );

  // Pulse counters and last-pulse timestamps, sampled on the falling edge.
  int cyc = 0;
  int n_press = 0, n_release = 0, n_click = 0, n_dclick = 0, n_long = 0, n_repeat = 0;
  int t_press = 0, t_release = 0, t_click = 0, t_dclick = 0, t_long = 0, t_repeat = 0;
  int n_viol = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (o_press)   begin n_press++;   t_press   = cyc; end
    if (o_release) begin n_release++; t_release = cyc; end
    if (o_click)   begin n_click++;   t_click   = cyc; end
    if (o_dclick)  begin n_dclick++;  t_dclick  = cyc; end
    if (o_long)    begin n_long++;    t_long    = cyc; end
    if (o_repeat)  begin n_repeat++;  t_repeat  = cyc; end
    if ((o_press && o_release) ||
        (int'(o_click) + int'(o_dclick) + int'(o_long) > 1)) n_viol++;
  end

  // Advance to just after the falling edge (after the monitor has sampled).
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_sync = 1'b0;
    step(4);
    checks++; if (o_held !== 1'b0)    begin errors++; $display("FAIL reset_held got %b expected 0", o_held); end
    checks++; if (o_press !== 1'b0)   begin errors++; $display("FAIL reset_press got %b expected 0", o_press); end
    checks++; if (o_release !== 1'b0) begin errors++; $display("FAIL reset_release got %b expected 0", o_release); end
    checks++; if (o_click !== 1'b0)   begin errors++; $display("FAIL reset_click got %b expected 0", o_click); end
    checks++; if (o_dclick !== 1'b0)  begin errors++; $display("FAIL reset_dclick got %b expected 0", o_dclick); end
    checks++; if (o_long !== 1'b0)    begin errors++; $display("FAIL reset_long got %b expected 0", o_long); end
    checks++; if (o_repeat !== 1'b0)  begin errors++; $display("FAIL reset_repeat got %b expected 0", o_repeat); end
    checks++; if (al_held !== 1'b0)   begin errors++; $display("FAIL reset_al_held got %b expected 0", al_held); end
    rst = 1'b0;
    step(4);
    checks++; if (n_press !== 0) begin errors++; $display("FAIL idle_no_press got %0d expected 0", n_press); end
    $display("test_reset done");
  endtask

  task automatic test_click();
    int p0, r0, c0, d0, l0, q0;
    p0 = n_press; r0 = n_release; c0 = n_click; d0 = n_dclick; l0 = n_long; q0 = n_repeat;
    i_sync = 1'b1; step(3);
    i_sync = 1'b0; step(10);
    checks++; if (n_press - p0 !== 1)   begin errors++; $display("FAIL click_press got %0d expected 1", n_press - p0); end
    checks++; if (n_release - r0 !== 1) begin errors++; $display("FAIL click_release got %0d expected 1", n_release - r0); end
    checks++; if (n_click - c0 !== 1)   begin errors++; $display("FAIL click_count got %0d expected 1", n_click - c0); end
    checks++; if (t_click - t_release !== 6) begin errors++; $display("FAIL click_delay got %0d expected 6", t_click - t_release); end
    checks++; if (n_dclick - d0 !== 0)  begin errors++; $display("FAIL click_dclick got %0d expected 0", n_dclick - d0); end
    checks++; if (n_long - l0 !== 0)    begin errors++; $display("FAIL click_long got %0d expected 0", n_long - l0); end
    checks++; if (n_repeat - q0 !== 0)  begin errors++; $display("FAIL click_repeat got %0d expected 0", n_repeat - q0); end
    $display("test_click done: click %0d cycles after release", t_click - t_release);
  endtask

  task automatic test_dclick();
    int p0, r0, c0, d0;
    p0 = n_press; r0 = n_release; c0 = n_click; d0 = n_dclick;
    i_sync = 1'b1; step(3);
    i_sync = 1'b0; step(2);
    i_sync = 1'b1; step(3);
    i_sync = 1'b0; step(12);
    checks++; if (n_press - p0 !== 2)   begin errors++; $display("FAIL dclick_press got %0d expected 2", n_press - p0); end
    checks++; if (n_release - r0 !== 2) begin errors++; $display("FAIL dclick_release got %0d expected 2", n_release - r0); end
    checks++; if (n_dclick - d0 !== 1)  begin errors++; $display("FAIL dclick_count got %0d expected 1", n_dclick - d0); end
    checks++; if (t_dclick !== t_release) begin errors++; $display("FAIL dclick_align got %0d expected %0d", t_dclick, t_release); end
    checks++; if (n_click - c0 !== 0)   begin errors++; $display("FAIL dclick_click got %0d expected 0", n_click - c0); end
    $display("test_dclick done");
  endtask

  task automatic test_long();
    int r0, c0, d0, l0, q0;
    r0 = n_release; c0 = n_click; d0 = n_dclick; l0 = n_long; q0 = n_repeat;
    // 21 cycles keeps the release clear of the third repeat slot.
    i_sync = 1'b1; step(21);
    i_sync = 1'b0; step(12);
    checks++; if (n_long - l0 !== 1)    begin errors++; $display("FAIL long_count got %0d expected 1", n_long - l0); end
    checks++; if (t_long - t_press !== 8) begin errors++; $display("FAIL long_delay got %0d expected 8", t_long - t_press); end
    checks++; if (n_release - r0 !== 1) begin errors++; $display("FAIL long_release got %0d expected 1", n_release - r0); end
    checks++; if (n_click - c0 !== 0)   begin errors++; $display("FAIL long_click got %0d expected 0", n_click - c0); end
    checks++; if (n_dclick - d0 !== 0)  begin errors++; $display("FAIL long_dclick got %0d expected 0", n_dclick - d0); end
`ifdef BUTTON_REPEAT_EN
    checks++; if (n_repeat - q0 !== 3)  begin errors++; $display("FAIL long_repeat got %0d expected 3", n_repeat - q0); end
    checks++; if (t_repeat - t_long !== 12) begin errors++; $display("FAIL long_repeat_last got %0d expected 12", t_repeat - t_long); end
`else
    checks++; if (n_repeat - q0 !== 0)  begin errors++; $display("FAIL long_repeat got %0d expected 0", n_repeat - q0); end
`endif
    $display("test_long done: long %0d cycles after press", t_long - t_press);
  endtask

  task automatic test_reset_cases();
    int r0, c0, d0;
    i_sync = 1'b1;
    rst = 1'b1; step(3);
    rst = 1'b0; step(1);
    checks++; if (o_press !== 1'b0) begin errors++; $display("FAIL rstheld_early got %b expected 0", o_press); end
    step(1);
    checks++; if (o_press !== 1'b1) begin errors++; $display("FAIL rstheld_press got %b expected 1", o_press); end
    checks++; if (o_held !== 1'b1)  begin errors++; $display("FAIL rstheld_held got %b expected 1", o_held); end
    step(2);
    r0 = n_release; c0 = n_click; d0 = n_dclick;
    i_sync = 1'b0; step(4);
    rst = 1'b1; step(2);
    rst = 1'b0; step(10);
    checks++; if (n_release - r0 !== 1) begin errors++; $display("FAIL rstgap_release got %0d expected 1", n_release - r0); end
    checks++; if (n_click - c0 !== 0)   begin errors++; $display("FAIL rstgap_click got %0d expected 0", n_click - c0); end
    checks++; if (n_dclick - d0 !== 0)  begin errors++; $display("FAIL rstgap_dclick got %0d expected 0", n_dclick - d0); end
    $display("test_reset_cases done");
  endtask

  task automatic test_active_low();
    i_sync_al = 1'b0; step(2);
    checks++; if (al_press !== 1'b1) begin errors++; $display("FAIL al_press got %b expected 1", al_press); end
    checks++; if (al_held !== 1'b1)  begin errors++; $display("FAIL al_held got %b expected 1", al_held); end
    step(1);
    checks++; if (al_press !== 1'b0) begin errors++; $display("FAIL al_press_width got %b expected 0", al_press); end
    i_sync_al = 1'b1; step(2);
    checks++; if (al_release !== 1'b1) begin errors++; $display("FAIL al_release got %b expected 1", al_release); end
    checks++; if (al_held !== 1'b0)    begin errors++; $display("FAIL al_held_off got %b expected 0", al_held); end
    step(10);
    $display("test_active_low done");
  endtask

  task automatic test_long_threshold();
    int r0, c0, l0;
    r0 = n_release; c0 = n_click; l0 = n_long;
    // Held 8 cycles: the fall is seen on the very cycle the long threshold hits.
    i_sync = 1'b1; step(8);
    i_sync = 1'b0; step(12);
    checks++; if (n_long - l0 !== 0)    begin errors++; $display("FAIL thr_long got %0d expected 0", n_long - l0); end
    checks++; if (n_click - c0 !== 1)   begin errors++; $display("FAIL thr_click got %0d expected 1", n_click - c0); end
    checks++; if (n_release - r0 !== 1) begin errors++; $display("FAIL thr_release got %0d expected 1", n_release - r0); end
    $display("test_long_threshold done");
  endtask

  initial begin
    test_reset();
    test_click();
    test_dclick();
    test_long();
    test_reset_cases();
    test_active_low();
    test_long_threshold();
    checks++; if (n_viol !== 0) begin errors++; $display("FAIL exclusion got %0d violations expected 0", n_viol); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
